r2_bf_last: RTL and testbench
=============================

R2_BF_LAST -- requirements
Module: r2_bf_last

Interface
REQ-001 Parameter FRAME_LEN, 64, output samples per frame; even, >=2.
REQ-002 Reset rst_n, asynchronous, active-low; clock clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clr  input  1  synchronous flush; discards partial pair and frame position.
REQ-006 in_valid  input  1  din_r/din_i carry a sample this cycle; no backpressure.
REQ-007 din_r  input  24  signed real part, from the upstream one-sample shift stage.
REQ-008 din_i  input  24  signed imaginary part.
REQ-009 out_valid  output  1  dout_r/dout_i valid this cycle.
REQ-010 dout_r  output  24  signed real result, registered.
REQ-011 dout_i  output  24  signed imaginary result, registered.
REQ-012 out_sof  output  1  high with first output of each frame.
REQ-013 out_eof  output  1  high with output number FRAME_LEN-1 of each frame.

Function
REQ-014 Block SHALL be the final radix-2 SDF butterfly with internal one-sample delay (even-sample register) and separate difference register.
REQ-015 Pair FSM SHALL have states EVEN (no held sample) and ODD (even sample held); phase advances only on in_valid; gaps of any length hold state and registers.
REQ-016 EVEN with in_valid: store din into even register; go ODD; no output produced by this event.
REQ-017 ODD with in_valid: with a=held, b=din, compute per component sum=(a+b)>>>1 and diff=(a-b)>>>1; go EVEN.
REQ-018 Arithmetic: operands sign-extended to 25 bits, add/sub exact, arithmetic right shift by 1 (floor), low 24 bits taken; no saturation or rounding.
REQ-019 Sum SHALL appear on dout with out_valid=1 in the cycle after the ODD sample edge (latency 1).
REQ-020 Diff SHALL be held in diff register with pend flag and appear with out_valid=1 in the following cycle (latency 2), regardless of in_valid that cycle.
REQ-021 An EVEN sample arriving in the diff-emission cycle SHALL be stored normally; the two events never conflict.
REQ-022 out_valid=0 in all other cycles; dout holds last value when out_valid=0.
REQ-023 Frame counter 0..FRAME_LEN-1 SHALL increment per output (out_valid=1) and wrap to 0 after FRAME_LEN-1.
REQ-024 out_sof=1 exactly when out_valid=1 and count=0; out_eof=1 exactly when out_valid=1 and count=FRAME_LEN-1; both 0 otherwise.
REQ-025 clr=1 SHALL force FSM to EVEN, clear pend, out_valid, counter, sof/eof next edge; clr beats simultaneous in_valid (sample dropped) and pending diff (discarded).
REQ-026 Output order per pair: sum then diff; consecutive pairs back-to-back yield continuous out_valid from the second cycle on.

Reset
REQ-027 rst_n low SHALL immediately clear: FSM=EVEN, even/diff registers=0, pend=0, counter=0, out_valid=0, dout_r=dout_i=0, out_sof=out_eof=0.
REQ-028 Reset mid-pair or mid-frame SHALL discard held sample and pending diff; first post-reset sample is EVEN.
REQ-029 No output SHALL be produced in the first cycle after rst_n release.

Verification
REQ-030 Pair (100,-8),(50,4) on consecutive cycles -> next cycle dout=(75,-2) valid, sof=1; following cycle dout=(25,-6) valid.
REQ-031 Rounding: pair (3,-3),(0,0) -> sum (1,-2), diff (1,-2); pair (-8388608,8388607),(8388607,-8388608) -> sum (-1,-1), diff (-8388608,8388607).
REQ-032 Gaps: x0, 5 idle cycles, x1 -> sum 1 cycle after x1, diff 2 cycles after, out_valid otherwise 0.
REQ-033 Continuous 2*FRAME_LEN samples, FRAME_LEN=64 -> out_valid continuous after first pair, out_eof on outputs 63 and 127, out_sof on outputs 0 and 64.
REQ-034 clr asserted with ODD sample present -> no sum/diff output, next sample treated as EVEN, counter restarts at 0.
REQ-035 rst_n pulsed low while diff pending -> outputs zero immediately, diff never emitted.

Source files
------------

// File: rtl/r2_bf_last_if.sv
// Sample/result bundle for the final radix-2 SDF butterfly.
// The master side feeds samples and flush; the slave side is the butterfly.
interface r2_bf_last_if;
    logic        clr;
    logic        in_valid;
    logic [23:0] din_r;
    logic [23:0] din_i;
    logic        out_valid;
    logic [23:0] dout_r;
    logic [23:0] dout_i;
    logic        out_sof;
    logic        out_eof;

    modport master (
        output clr,
        output in_valid,
        output din_r,
        output din_i,
        input  out_valid,
        input  dout_r,
        input  dout_i,
        input  out_sof,
        input  out_eof
    );

    modport slave (
        input  clr,
        input  in_valid,
        input  din_r,
        input  din_i,
        output out_valid,
        output dout_r,
        output dout_i,
        output out_sof,
        output out_eof
    );
endinterface

// File: rtl/r2_bf_last.sv
// Final radix-2 SDF butterfly: pairs consecutive valid samples (a, b) and emits
// (a+b)>>>1 one cycle after b, then (a-b)>>>1 the cycle after that, with
// frame start/end markers counted over emitted outputs.
module r2_bf_last #(
    parameter int unsigned FRAME_LEN = 64
) (
    input logic         clk,
    input logic         rst_n,
    r2_bf_last_if.slave bf_io
);

    localparam int unsigned CntW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        StEven,
        StOdd
    } state_e;

    state_e state_q, state_d;

    // Held even sample
    logic [23:0] even_r_q, even_r_d;
    logic [23:0] even_i_q, even_i_d;

    // Difference waiting for its output slot
    logic [23:0] diff_r_q, diff_r_d;
    logic [23:0] diff_i_q, diff_i_d;
    logic        pend_q, pend_d;

    // Registered output stage
    logic        out_valid_q, out_valid_d;
    logic [23:0] dout_r_q, dout_r_d;
    logic [23:0] dout_i_q, dout_i_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;

    // Index of the next output within the frame
    logic [CntW-1:0] cnt_q, cnt_d;

    // Butterfly datapath: 25-bit exact sum/difference, floor halving
    logic signed [24:0] sum_r_full, sum_i_full;
    logic signed [24:0] dif_r_full, dif_i_full;
    logic        [23:0] sum_r, sum_i;
    logic        [23:0] dif_r, dif_i;

    // Sign-extend both operands, add/subtract exactly, then arithmetic shift by one
    always_comb begin
        sum_r_full = $signed({even_r_q[23], even_r_q}) + $signed({bf_io.din_r[23], bf_io.din_r});
        sum_i_full = $signed({even_i_q[23], even_i_q}) + $signed({bf_io.din_i[23], bf_io.din_i});
        dif_r_full = $signed({even_r_q[23], even_r_q}) - $signed({bf_io.din_r[23], bf_io.din_r});
        dif_i_full = $signed({even_i_q[23], even_i_q}) - $signed({bf_io.din_i[23], bf_io.din_i});
        sum_r      = 24'(sum_r_full >>> 1);
        sum_i      = 24'(sum_i_full >>> 1);
        dif_r      = 24'(dif_r_full >>> 1);
        dif_i      = 24'(dif_i_full >>> 1);
    end

    // Pair FSM, diff scheduling, output selection and frame marking
    always_comb begin
        state_d     = state_q;
        even_r_d    = even_r_q;
        even_i_d    = even_i_q;
        diff_r_d    = diff_r_q;
        diff_i_d    = diff_i_q;
        pend_d      = 1'b0;
        out_valid_d = 1'b0;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        cnt_d       = cnt_q;

        if (bf_io.clr) begin
            // Flush wins over any incoming sample and any pending diff
            state_d = StEven;
            cnt_d   = '0;
        end else begin
            // A pending diff always owns this slot; an odd sample cannot coincide
            // with it because the FSM is back in StEven right after the sum.
            if (pend_q) begin
                out_valid_d = 1'b1;
                dout_r_d    = diff_r_q;
                dout_i_d    = diff_i_q;
            end

            if (bf_io.in_valid) begin
                unique case (state_q)
                    StEven: begin
                        even_r_d = bf_io.din_r;
                        even_i_d = bf_io.din_i;
                        state_d  = StOdd;
                    end
                    StOdd: begin
                        out_valid_d = 1'b1;
                        dout_r_d    = sum_r;
                        dout_i_d    = sum_i;
                        diff_r_d    = dif_r;
                        diff_i_d    = dif_i;
                        pend_d      = 1'b1;
                        state_d     = StEven;
                    end
                    default: state_d = StEven;
                endcase
            end

            if (out_valid_d) begin
                sof_d = (cnt_q == '0);
                eof_d = (cnt_q == CntMax);
                cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEven;
            even_r_q    <= '0;
            even_i_q    <= '0;
            diff_r_q    <= '0;
            diff_i_q    <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            even_r_q    <= even_r_d;
            even_i_q    <= even_i_d;
            diff_r_q    <= diff_r_d;
            diff_i_q    <= diff_i_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bf_io.out_valid = out_valid_q;
    assign bf_io.dout_r    = dout_r_q;
    assign bf_io.dout_i    = dout_i_q;
    assign bf_io.out_sof   = sof_q;
    assign bf_io.out_eof   = eof_q;

`ifndef SYNTHESIS
    // Frame markers only ever accompany a valid output
    a_sof_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (sof_q || eof_q) |-> out_valid_q);
    // A pending diff implies the pair has closed
    a_pend_even: assert property (@(posedge clk) disable iff (!rst_n)
        pend_q |-> (state_q == StEven));
`endif

endmodule

// File: tb/tb_r2_bf_last.sv
// Bench for r2_bf_last: table of butterfly pairs, directed gap/flush/reset
// sequences, and randomized streams against an array-based reference model.
module tb_r2_bf_last;

    localparam int FrameLen = 64;
    localparam int MaxN     = 700;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    r2_bf_last_if bus ();

    r2_bf_last #(.FRAME_LEN(FrameLen)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bf_io (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int ar; int ai; int br; int bi;
        int sr; int si; int dr; int di;
    } vec_t;
    vec_t vecs[6];

    // Per-cycle stimulus and expectation arrays
    bit iv[MaxN + 1];
    bit ic[MaxN + 1];
    int ir[MaxN + 1];
    int ii[MaxN + 1];
    bit ev[MaxN + 1];
    bit es[MaxN + 1];
    bit ee[MaxN + 1];
    int er[MaxN + 1];
    int ei[MaxN + 1];
    int sof_idx[$];
    int eof_idx[$];

    function automatic int rd_r();
        return int'($signed(bus.dout_r));
    endfunction

    function automatic int rd_i();
        return int'($signed(bus.dout_i));
    endfunction

    function automatic int fdiv2(input longint s);
        return int'((s >= 0) ? s / 2 : -((-s + 1) / 2));
    endfunction

    function automatic int rnd24();
        logic [23:0] x;
        int unsigned k;
        k = $urandom_range(0, 7);
        x = $urandom;
        if (k == 0) return -8388608;
        if (k == 1) return 8388607;
        return int'($signed(x));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
    endtask

    // Present inputs for one edge, then settle at the following negedge
    task automatic tick(input bit v, input int r, input int i, input bit c);
        bus.in_valid = v;
        bus.din_r    = 24'(r);
        bus.din_i    = 24'(i);
        bus.clr      = c;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Build expectations from the pairing/frame rules, then drive and compare
    task automatic run_seq(input int n, input string name);
        bit held;
        int hr, hi, cnt, last_r, last_i, oidx;
        longint a, b;
        held = 1'b0;
        for (int t = 0; t <= n; t++) ev[t] = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (ic[t]) begin
                held  = 1'b0;
                ev[t] = 1'b0;
            end else if (iv[t]) begin
                if (!held) begin
                    hr = ir[t]; hi = ii[t]; held = 1'b1;
                end else begin
                    a = hr; b = ir[t];
                    ev[t] = 1'b1; er[t] = fdiv2(a + b);
                    ev[t + 1] = 1'b1; er[t + 1] = fdiv2(a - b);
                    a = hi; b = ii[t];
                    ei[t] = fdiv2(a + b);
                    ei[t + 1] = fdiv2(a - b);
                    held = 1'b0;
                end
            end
        end
        cnt = 0; last_r = 0; last_i = 0;
        for (int t = 0; t < n; t++) begin
            es[t] = 1'b0; ee[t] = 1'b0;
            if (ic[t]) cnt = 0;
            if (ev[t]) begin
                es[t] = (cnt == 0);
                ee[t] = (cnt == FrameLen - 1);
                cnt = (cnt + 1) % FrameLen;
                last_r = er[t]; last_i = ei[t];
            end
            er[t] = last_r; ei[t] = last_i;
        end

        do_reset();
        sof_idx.delete();
        eof_idx.delete();
        oidx = 0;
        for (int t = 0; t < n; t++) begin
            tick(iv[t], ir[t], ii[t], ic[t]);
            tests++;
            if (bus.out_valid !== ev[t] || bus.out_sof !== es[t] || bus.out_eof !== ee[t]
                || rd_r() != er[t] || rd_i() != ei[t]) begin
                fails++;
                $display("FAIL %s cycle %0d: got v=%0d sof=%0d eof=%0d dout=(%0d,%0d), expected v=%0d sof=%0d eof=%0d dout=(%0d,%0d)",
                         name, t, bus.out_valid, bus.out_sof, bus.out_eof, rd_r(), rd_i(),
                         ev[t], es[t], ee[t], er[t], ei[t]);
            end
            if (bus.out_valid === 1'b1) begin
                if (bus.out_sof === 1'b1) sof_idx.push_back(oidx);
                if (bus.out_eof === 1'b1) eof_idx.push_back(oidx);
                oidx++;
            end
        end
    endtask

    initial begin
        vecs[0] = '{100, -8, 50, 4, 75, -2, 25, -6};
        vecs[1] = '{3, -3, 0, 0, 1, -2, 1, -2};
        vecs[2] = '{-8388608, 8388607, 8388607, -8388608, -1, -1, -8388608, 8388607};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{7, -1, 2, -2, 4, -2, 2, 0};
        vecs[5] = '{-5, 1, -6, 1, -6, 1, 0, 0};

        idle_inputs();
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_dout_r", rd_r(), 0);
        chk("rst_dout_i", rd_i(), 0);
        chk("rst_sof", bus.out_sof, 0);
        chk("rst_eof", bus.out_eof, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("post_rst_valid", bus.out_valid, 0);

        // Table of pairs: sum after the odd edge, diff one cycle later
        foreach (vecs[k]) begin
            tick(1, vecs[k].ar, vecs[k].ai, 0);
            chk("vec_even_valid", bus.out_valid, 0);
            tick(1, vecs[k].br, vecs[k].bi, 0);
            chk("vec_sum_valid", bus.out_valid, 1);
            chk("vec_sum_r", rd_r(), vecs[k].sr);
            chk("vec_sum_i", rd_i(), vecs[k].si);
            chk("vec_sum_sof", bus.out_sof, (k == 0) ? 1 : 0);
            tick(0, 0, 0, 0);
            chk("vec_diff_valid", bus.out_valid, 1);
            chk("vec_diff_r", rd_r(), vecs[k].dr);
            chk("vec_diff_i", rd_i(), vecs[k].di);
            chk("vec_diff_eof", bus.out_eof, 0);
        end

        // Gap of five idle cycles inside a pair
        tick(1, 10, 20, 0);
        chk("gap_x0_valid", bus.out_valid, 0);
        for (int g = 0; g < 5; g++) begin
            tick(0, 0, 0, 0);
            chk("gap_idle_valid", bus.out_valid, 0);
        end
        tick(1, 4, -6, 0);
        chk("gap_sum_valid", bus.out_valid, 1);
        chk("gap_sum_r", rd_r(), 7);
        chk("gap_sum_i", rd_i(), 7);
        tick(0, 0, 0, 0);
        chk("gap_diff_valid", bus.out_valid, 1);
        chk("gap_diff_r", rd_r(), 3);
        chk("gap_diff_i", rd_i(), 13);
        tick(0, 0, 0, 0);
        chk("gap_after_valid", bus.out_valid, 0);
        chk("gap_hold_r", rd_r(), 3);

        // Flush with an odd sample present
        do_reset();
        tick(1, 1, 1, 0);
        tick(1, 3, 3, 0);
        chk("clr_pre_sum", rd_r(), 2);
        tick(0, 0, 0, 0);
        chk("clr_pre_diff", rd_r(), -1);
        tick(1, 8, 8, 0);
        tick(1, 9, 9, 1);
        chk("clr_drop_valid", bus.out_valid, 0);
        chk("clr_hold_r", rd_r(), -1);
        tick(0, 0, 0, 0);
        chk("clr_idle_valid", bus.out_valid, 0);
        tick(1, 10, 0, 0);
        chk("clr_next_even", bus.out_valid, 0);
        tick(1, 20, 0, 0);
        chk("clr_sum_valid", bus.out_valid, 1);
        chk("clr_sum_r", rd_r(), 15);
        chk("clr_sum_sof", bus.out_sof, 1);
        tick(0, 0, 0, 0);
        chk("clr_diff_r", rd_r(), -5);
        chk("clr_diff_sof", bus.out_sof, 0);

        // Asynchronous reset while a diff is pending
        do_reset();
        tick(1, 200, 0, 0);
        tick(1, 100, 0, 0);
        chk("ar_sum_r", rd_r(), 150);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_dout_r", rd_r(), 0);
        chk("ar_sof", bus.out_sof, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        chk("ar_no_diff1", bus.out_valid, 0);
        tick(0, 0, 0, 0);
        chk("ar_no_diff2", bus.out_valid, 0);
        tick(1, 6, 2, 0);
        chk("ar_first_even", bus.out_valid, 0);
        tick(1, 2, 6, 0);
        chk("ar_sum_valid", bus.out_valid, 1);
        chk("ar_sum_r", rd_r(), 4);
        chk("ar_sum_i", rd_i(), 4);
        chk("ar_sum_sof", bus.out_sof, 1);

        // Two back-to-back frames
        for (int t = 0; t < 131; t++) begin
            iv[t] = (t < 2 * FrameLen);
            ic[t] = 1'b0;
            ir[t] = rnd24();
            ii[t] = rnd24();
        end
        run_seq(131, "cont");
        chk("cont_sof_count", sof_idx.size(), 2);
        chk("cont_eof_count", eof_idx.size(), 2);
        if (sof_idx.size() == 2 && eof_idx.size() == 2) begin
            chk("cont_sof0", sof_idx[0], 0);
            chk("cont_sof1", sof_idx[1], 64);
            chk("cont_eof0", eof_idx[0], 63);
            chk("cont_eof1", eof_idx[1], 127);
        end

        // Random gaps and flushes
        for (int t = 0; t < 600; t++) begin
            iv[t] = (t < 596) && ($urandom_range(0, 9) < 7);
            ic[t] = (t < 596) && ($urandom_range(0, 49) == 0);
            ir[t] = rnd24();
            ii[t] = rnd24();
        end
        run_seq(600, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
